// File: rtl/wisc_isa_pkg.sv
// Shared WISC ISA definitions for the program loader and instruction packer.
// Holds opcode constants, loader error codes, the loader state enum and the
// packed field bundle handed to the packer.
package wisc_isa_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IMM_W  = 16;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Loader error codes
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ld_state_e;

    // Structured instruction fields as presented by the loader's source
    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       rd;
        logic [3:0]       rs;
        logic [3:0]       rt;
        logic [2:0]       cond;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    // True when v fits in a two's-complement field whose sign bit is v[msb]
    function automatic logic fits_signed(input logic [IMM_W-1:0] v, input int unsigned msb);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < IMM_W; i++) begin
            if (i > msb && v[i] != v[msb]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/wisc_instr_pack.sv
// Combinational WISC instruction encoder: the exact inverse of decode.
// Ports:
//   fields    - op/rd/rs/rt/cond/imm bundle
//   word      - encoded 16-bit instruction
//   range_err - immediate does not fit (or misaligned) for this opcode
module wisc_instr_pack
    import wisc_isa_pkg::*;
(
    input  instr_fields_t       fields,
    output logic [WORD_W-1:0]   word,
    output logic                range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (fields.op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                word = {fields.op, fields.rd, fields.rs, fields.rt};
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                word      = {fields.op, fields.rd, fields.rs, fields.imm[3:0]};
                range_err = |fields.imm[15:4];
            end
            OP_LW: begin
                word      = {fields.op, fields.rd, fields.rs, fields.imm[4:1]};
                range_err = fields.imm[0] | ~fits_signed(fields.imm, 4);
            end
            // Store-data register sits where rd would be
            OP_SW: begin
                word      = {fields.op, fields.rt, fields.rs, fields.imm[4:1]};
                range_err = fields.imm[0] | ~fits_signed(fields.imm, 4);
            end
            OP_LLB, OP_LHB: begin
                word      = {fields.op, fields.rd, fields.imm[7:0]};
                range_err = |fields.imm[15:8];
            end
            OP_B: begin
                word      = {fields.op, fields.cond, fields.imm[9:1]};
                range_err = fields.imm[0] | ~fits_signed(fields.imm, 9);
            end
            OP_BR: begin
                word = {fields.op, fields.cond, 1'b0, fields.rs, 4'h0};
            end
            OP_PCS: begin
                word = {fields.op, fields.rd, 8'h00};
            end
            default: begin
                word = 16'hF000;
            end
        endcase
    end

endmodule

// File: rtl/wisc_prog_loader.sv
// Streams encoded WISC instructions into instruction memory at consecutive
// halfword addresses starting at BASE_ADDR.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - begin a load (IDLE/DONE/ERR only)
//   in_valid/in_ready, in_op/rd/rs/rt/cond/imm, in_last - field bundle stream
//   mem_addr/mem_data/mem_wr - one-cycle memory write per accepted word
//   done, err, err_code      - completion / abort status (held until start)
//   word_count               - words written in the current load
// Build option: WISC_LOADER_RANGE_CHECK_EN makes out-of-range immediates
// abort the load; otherwise they are truncated and written.
module wisc_prog_loader
    import wisc_isa_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          MAX_WORDS = 256,
    localparam int unsigned         CNT_W     = $clog2(MAX_WORDS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_op,
    input  logic [3:0]          in_rd,
    input  logic [3:0]          in_rs,
    input  logic [3:0]          in_rt,
    input  logic [2:0]          in_cond,
    input  logic [15:0]         in_imm,
    input  logic                in_last,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [15:0]         mem_data,
    output logic                mem_wr,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [CNT_W-1:0]    word_count
);

`ifdef WISC_LOADER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    ld_state_e           state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_data_q, mem_data_d;
    logic                mem_wr_q, mem_wr_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                ovf_q, ovf_d;

    instr_fields_t       fields;
    logic [15:0]         enc_word;
    logic                enc_range_err;
    logic                range_hit;
    logic                handshake;

    assign fields = '{op: in_op, rd: in_rd, rs: in_rs, rt: in_rt,
                      cond: in_cond, imm: in_imm};

    wisc_instr_pack u_pack (
        .fields    (fields),
        .word      (enc_word),
        .range_err (enc_range_err)
    );

    assign range_hit = RANGE_CHECK_EN & enc_range_err;
    // in_ready_q mirrors state_q == ST_LOAD
    assign handshake = in_ready_q & in_valid;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wr_d     = 1'b0;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        word_count_d = word_count_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    mem_addr_d   = BASE_ADDR;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    err_code_d   = ERR_NONE;
                    ovf_d        = 1'b0;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    if (range_hit) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_RANGE;
                    end else begin
                        mem_wr_d     = 1'b1;
                        mem_data_d   = enc_word;
                        // First word goes to BASE_ADDR, already loaded by start
                        mem_addr_d   = (word_count_q == '0) ? mem_addr_q
                                                            : mem_addr_q + ADDR_W'(2);
                        word_count_d = word_count_q + CNT_W'(1);
                        if (in_last || word_count_q == CNT_W'(MAX_WORDS - 1)) begin
                            state_d = ST_DRAIN;
                            ovf_d   = ~in_last;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (ovf_q) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_OVF;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_data_q   <= '0;
            mem_wr_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            word_count_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wr_q     <= mem_wr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            word_count_q <= word_count_d;
            ovf_q        <= ovf_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wr     = mem_wr_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_wisc_prog_loader.sv
// Self-checking bench for wisc_prog_loader: directed programs plus random
// programs checked against an arithmetic encoding model.
module tb_wisc_prog_loader;

`ifdef WISC_LOADER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [2:0]  cond;
        logic [15:0] imm;
        logic        last;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [3:0]  in_op, in_rd, in_rs, in_rt;
    logic [2:0]  in_cond;
    logic [15:0] in_imm;

    logic        in_ready, mem_wr, done, err;
    logic [15:0] mem_addr, mem_data;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    logic        in_ready_s, mem_wr_s, done_s, err_s;
    logic [15:0] mem_addr_s, mem_data_s;
    logic [1:0]  err_code_s;
    logic [2:0]  word_count_s;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] obs_q[$];
    logic [31:0] obs_s_q[$];
    bundle_t     prog[$];

    always #5 clk = ~clk;

    wisc_prog_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_cond(in_cond),
        .in_imm(in_imm), .in_last(in_last), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wr(mem_wr), .done(done), .err(err), .err_code(err_code),
        .word_count(word_count)
    );

    // Small-capacity instance near the top of memory: overflow and address wrap
    wisc_prog_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFC), .MAX_WORDS(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_cond(in_cond),
        .in_imm(in_imm), .in_last(in_last), .mem_addr(mem_addr_s), .mem_data(mem_data_s),
        .mem_wr(mem_wr_s), .done(done_s), .err(err_s), .err_code(err_code_s),
        .word_count(word_count_s)
    );

    // Write monitor
    always @(negedge clk) begin
        if (mem_wr === 1'b1)   obs_q.push_back({mem_addr, mem_data});
        if (mem_wr_s === 1'b1) obs_s_q.push_back({mem_addr_s, mem_data_s});
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic bundle_t mk(input int op, input int rd, input int rs, input int rt,
                                   input int cond, input int imm, input bit last);
        bundle_t b;
        b.op = 4'(op); b.rd = 4'(rd); b.rs = 4'(rs); b.rt = 4'(rt);
        b.cond = 3'(cond); b.imm = 16'(imm); b.last = last;
        return b;
    endfunction

    // Reference encoder computed from field arithmetic
    function automatic void model_enc(input bundle_t b, output logic [15:0] w, output bit bad);
        int s, u, v, op;
        s = int'($signed(b.imm));
        u = int'(b.imm);
        op = int'(b.op);
        bad = 1'b0;
        v = op * 4096;
        case (op)
            0, 1, 2, 3, 7: v = v + int'(b.rd) * 256 + int'(b.rs) * 16 + int'(b.rt);
            4, 5, 6: begin
                v = v + int'(b.rd) * 256 + int'(b.rs) * 16 + u % 16;
                bad = (u > 15);
            end
            8, 9: begin
                v = v + ((op == 8) ? int'(b.rd) : int'(b.rt)) * 256 + int'(b.rs) * 16
                      + ((s >>> 1) & 15);
                bad = (s < -16) || (s > 14) || (s % 2 != 0);
            end
            10, 11: begin
                v = v + int'(b.rd) * 256 + u % 256;
                bad = (u > 255);
            end
            12: begin
                v = v + int'(b.cond) * 512 + ((s >>> 1) & 511);
                bad = (s < -512) || (s > 510) || (s % 2 != 0);
            end
            13: v = v + int'(b.cond) * 512 + int'(b.rs) * 16;
            14: v = v + int'(b.rd) * 256;
            default: v = 61440;
        endcase
        w = 16'(v);
    endfunction

    // Expected writes and final status for a program
    function automatic void model_run(input bundle_t p[$], input int base, input int max_w,
                                      output logic [31:0] wr[$], output int code,
                                      output bit done_e);
        logic [15:0] w;
        bit bad;
        wr = {};
        code = 0;
        done_e = 1'b0;
        foreach (p[i]) begin
            model_enc(p[i], w, bad);
            if (RC && bad) begin
                code = 1;
                return;
            end
            wr.push_back({16'((base + 2 * wr.size()) % 65536), w});
            if (p[i].last) begin
                done_e = 1'b1;
                return;
            end
            if (wr.size() == max_w) begin
                code = 2;
                return;
            end
        end
    endfunction

    function automatic bundle_t rand_bundle(input bit last);
        int op, imm;
        op = int'($urandom_range(0, 15));
        case (op)
            4, 5, 6: imm = int'($urandom_range(0, 15));
            8, 9:    imm = 2 * (int'($urandom_range(0, 15)) - 8);
            10, 11:  imm = int'($urandom_range(0, 255));
            12:      imm = 2 * (int'($urandom_range(0, 511)) - 256);
            default: imm = int'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) imm = int'($urandom);
        return mk(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), imm, last);
    endfunction

    task automatic put(input bundle_t b);
        in_op = b.op; in_rd = b.rd; in_rs = b.rs; in_rt = b.rt;
        in_cond = b.cond; in_imm = b.imm; in_last = b.last;
    endtask

    // Start a load and stream prog while the selected loader is ready
    task automatic run_prog(input bit use_s, input bit start_mid);
        obs_q.delete();
        obs_s_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("ready_after_start", 32'(use_s ? in_ready_s : in_ready), 32'd1);
        foreach (prog[i]) begin
            if ((use_s ? in_ready_s : in_ready) !== 1'b1) break;
            put(prog[i]);
            in_valid = 1'b1;
            start = start_mid && (i == 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_prog(input string tag, input bit use_s);
        logic [31:0] wr[$];
        logic [31:0] ob[$];
        int code;
        bit done_e;
        model_run(prog, use_s ? 16'hFFFC : 0, use_s ? 4 : 256, wr, code, done_e);
        ob = use_s ? obs_s_q : obs_q;
        chk({tag, "_nwr"}, 32'(ob.size()), 32'(wr.size()));
        foreach (wr[i]) chk({tag, "_wr"}, (i < ob.size()) ? ob[i] : 32'hxxxx_xxxx, wr[i]);
        chk({tag, "_done"}, 32'(use_s ? done_s : done), 32'(done_e));
        chk({tag, "_err"}, 32'(use_s ? err_s : err), 32'(code != 0));
        chk({tag, "_code"}, 32'(use_s ? err_code_s : err_code), 32'(code));
        chk({tag, "_cnt"}, use_s ? 32'(word_count_s) : 32'(word_count), 32'(wr.size()));
    endtask

    task automatic check_reset_values();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_cnt", 32'(word_count), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h0000);
        chk("rst_data", 32'(mem_data), 32'h0000);
        chk("rst_addr_s", 32'(mem_addr_s), 32'hFFFC);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        put(mk(0, 0, 0, 0, 0, 0, 1'b0));
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // ADD r1,r2,r3
        prog = {mk(0, 1, 2, 3, 0, 0, 1'b1)};
        run_prog(1'b0, 1'b0);
        check_prog("add", 1'b0);
        chk("add_const", obs_q.size() > 0 ? obs_q[0] : 32'hxxxx_xxxx, 32'h0000_0123);

        // LW then SW, back to back
        prog = {mk(8, 4, 5, 0, 0, -4, 1'b0), mk(9, 0, 5, 3, 0, 6, 1'b1)};
        run_prog(1'b0, 1'b0);
        check_prog("lwsw", 1'b0);
        chk("lw_const", obs_q.size() > 0 ? obs_q[0] : 32'hxxxx_xxxx, 32'h0000_845E);
        chk("sw_const", obs_q.size() > 1 ? obs_q[1] : 32'hxxxx_xxxx, 32'h0002_9353);

        // B then HLT
        prog = {mk(12, 0, 0, 0, 2, -6, 1'b0), mk(15, 0, 0, 0, 0, 0, 1'b1)};
        run_prog(1'b0, 1'b0);
        check_prog("bhlt", 1'b0);
        chk("b_const", obs_q.size() > 0 ? obs_q[0] : 32'hxxxx_xxxx, 32'h0000_C5FD);
        chk("hlt_const", obs_q.size() > 1 ? obs_q[1] : 32'hxxxx_xxxx, 32'h0002_F000);

        // LLB with an immediate that does not fit 8 bits
        prog = {mk(10, 7, 0, 0, 0, 'h1AB, 1'b1)};
        run_prog(1'b0, 1'b0);
        check_prog("llb", 1'b0);
        chk("llb_status", {30'd0, err, done}, RC ? 32'd2 : 32'd1);

        // start together with in_valid: bundle must not be taken
        obs_q.delete();
        @(negedge clk);
        put(mk(0, 1, 1, 1, 0, 0, 1'b1));
        start = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovl_nowr", 32'(obs_q.size()), 32'd0);
        chk("ovl_ready", 32'(in_ready), 32'd1);
        prog = {mk(15, 0, 0, 0, 0, 0, 1'b1)};
        put(prog[0]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_prog("ovl", 1'b0);

        // Random programs; some have a start pulse mid-load that must be ignored
        for (int t = 0; t < 24; t++) begin
            int n;
            n = int'($urandom_range(1, 8));
            prog = {};
            for (int i = 0; i < n; i++) prog.push_back(rand_bundle(i == n - 1));
            run_prog(1'b0, $urandom_range(0, 1) == 1);
            check_prog("rand", 1'b0);
        end

        // Reset on the handshake edge suppresses the pending write
        obs_q.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        put(mk(0, 1, 2, 3, 0, 0, 1'b0));
        in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_nowr", 32'(obs_q.size()), 32'd0);
        check_reset_values();

        // Capacity overflow with address wrap on the small instance
        prog = {};
        for (int i = 0; i < 5; i++) prog.push_back(mk(14, 0, 0, 0, 0, 0, 1'b0));
        run_prog(1'b1, 1'b0);
        check_prog("ovf", 1'b1);
        chk("ovf_ready", 32'(in_ready_s), 32'd0);
        chk("ovf_last_addr", obs_s_q.size() > 3 ? obs_s_q[3] : 32'hxxxx_xxxx, 32'h0002_E000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
